// File: rtl/riscv_pkg.sv
// Shared decode constants and bundles for the
// RV32I five-stage pipeline.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI
  } alu_code_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  function automatic alu_code_e alu_dec(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_op
  );
    case (f3)
      3'b000:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file, two read ports,
// one write port, write-through read bypass.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] mem_q [32];

  // clear on reset; x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // combinational reads, same-cycle write wins
  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, regfile, decoder,
// branch/jump resolution and hazard detection.
module id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC_if,
  input  logic        IF_flush,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  Rd_ex,
  input  logic        RegWrite_mem,
  input  logic        MemRead_mem,
  input  logic [4:0]  Rd_mem,
  input  logic [31:0] ALUResult_mem,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic        IFWrite,
  output logic [31:0] PC_id,
  output logic [31:0] Rs1Data_id,
  output logic [31:0] Rs2Data_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs1_id,
  output logic [4:0]  Rs2_id,
  output logic [4:0]  Rd_id,
  output logic        RegWrite_id,
  output logic        MemRead_id,
  output logic        MemWrite_id,
  output logic        MemtoReg_id,
  output logic        ALUSrc_id,
  output logic [3:0]  ALUCode_id
);

  if_id_t      ifid_q, ifid_d;
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic        is_lui, is_auipc, is_jal, is_jalr;
  logic        is_br, is_ld, is_st, is_opi, is_op;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rf1, rf2, op1, op2, imm, tgt_imm;
  logic        rw, mr, mw, m2r, src, link;
  logic        use1, use2, brj;
  logic        hit_ex, hit_mem, stall, taken;
  alu_code_e   alu;

  assign ins = ifid_q.instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];

  // next IF/ID: hold on stall, squash on flush
  always_comb begin
    ifid_d = ifid_q;
    if (IFWrite) begin
      ifid_d.pc    = PC_if;
      ifid_d.instr = IF_flush ? NOP : Instruction_if;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (reset) ifid_q <= '{instr: NOP, pc: RESET_PC};
    else       ifid_q <= ifid_d;
  end

  regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rf1),
    .rd2_o (rf2),
    .we_i  (RegWrite_wb),
    .wa_i  (WriteReg_wb),
    .wd_i  (WriteData_wb)
  );

  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;
  assign is_opi   = opc == OPC_OPIMM;
  assign is_op    = opc == OPC_OP;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // main decoder; links carry PC+4 through the ALU
  always_comb begin
    rw   = 1'b0;
    mr   = 1'b0;
    mw   = 1'b0;
    m2r  = 1'b0;
    src  = 1'b0;
    link = 1'b0;
    use1 = 1'b0;
    use2 = 1'b0;
    alu  = ALU_ADD;
    imm  = '0;
    unique case (1'b1)
      is_lui: begin
        rw = 1'b1; src = 1'b1;
        alu = ALU_LUI; imm = imm_u;
      end
      is_auipc: begin
        rw = 1'b1; src = 1'b1;
        link = 1'b1; imm = imm_u;
      end
      is_jal: begin
        rw = 1'b1; src = 1'b1;
        link = 1'b1; imm = 32'd4;
      end
      is_jalr: begin
        rw = 1'b1; src = 1'b1; use1 = 1'b1;
        link = 1'b1; imm = 32'd4;
      end
      is_br: begin
        use1 = 1'b1; use2 = 1'b1; imm = imm_b;
      end
      is_ld: begin
        rw = 1'b1; mr = 1'b1; m2r = 1'b1;
        src = 1'b1; use1 = 1'b1; imm = imm_i;
      end
      is_st: begin
        mw = 1'b1; src = 1'b1;
        use1 = 1'b1; use2 = 1'b1; imm = imm_s;
      end
      is_opi: begin
        rw = 1'b1; src = 1'b1; use1 = 1'b1;
        imm = imm_i;
        alu = alu_dec(f3, ins[30], 1'b0);
      end
      is_op: begin
        rw = 1'b1; use1 = 1'b1; use2 = 1'b1;
        alu = alu_dec(f3, ins[30], 1'b1);
      end
      default: ;
    endcase
  end

  assign brj = is_br | is_jalr;

  assign hit_ex = (Rd_ex != '0) &&
                  ((use1 && Rd_ex == rs1) ||
                   (use2 && Rd_ex == rs2));
  assign hit_mem = (Rd_mem != '0) &&
                   ((use1 && Rd_mem == rs1) ||
                    (use2 && Rd_mem == rs2));

  assign stall = (MemRead_ex && hit_ex) ||
                 (brj && RegWrite_ex && hit_ex) ||
                 (brj && MemRead_mem && hit_mem);

  // ALU results in MEM feed branch compare / JALR base
  always_comb begin
    op1 = rf1;
    op2 = rf2;
    if (RegWrite_mem && !MemRead_mem && Rd_mem != '0) begin
      if (Rd_mem == rs1) op1 = ALUResult_mem;
      if (Rd_mem == rs2) op2 = ALUResult_mem;
    end
  end

  // branch condition evaluation
  always_comb begin
    case (f3)
      F3_BEQ:  taken = op1 == op2;
      F3_BNE:  taken = op1 != op2;
      F3_BLT:  taken = $signed(op1) < $signed(op2);
      F3_BGE:  taken = $signed(op1) >= $signed(op2);
      F3_BLTU: taken = op1 < op2;
      F3_BGEU: taken = op1 >= op2;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_imm = is_br  ? imm_b :
                   is_jal ? imm_j : imm;

  assign JumpAddr = is_jalr ? ((op1 + imm_i) & ~32'd1)
                            : (ifid_q.pc + tgt_imm);

  assign IFWrite     = ~stall;
  assign Branch      = is_br & taken & ~stall;
  assign Jump        = (is_jal | is_jalr) & ~stall;
  assign PC_id       = ifid_q.pc;
  assign Rs1Data_id  = link ? ifid_q.pc : rf1;
  assign Rs2Data_id  = rf2;
  assign Imm_id      = imm;
  assign Rs1_id      = rs1;
  assign Rs2_id      = rs2;
  assign Rd_id       = ins[11:7];
  assign RegWrite_id = rw & ~stall;
  assign MemRead_id  = mr & ~stall;
  assign MemWrite_id = mw & ~stall;
  assign MemtoReg_id = m2r;
  assign ALUSrc_id   = src;
  assign ALUCode_id  = alu;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus
// random traffic against a behavioural model.
module tb_id_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, IF_flush;
  logic [31:0] Instruction_if, PC_if;
  logic        RegWrite_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        RegWrite_ex, MemRead_ex;
  logic [4:0]  Rd_ex;
  logic        RegWrite_mem, MemRead_mem;
  logic [4:0]  Rd_mem;
  logic [31:0] ALUResult_mem;
  logic        Branch, Jump, IFWrite;
  logic [31:0] JumpAddr, PC_id, Rs1Data_id, Rs2Data_id, Imm_id;
  logic [4:0]  Rs1_id, Rs2_id, Rd_id;
  logic        RegWrite_id, MemRead_id, MemWrite_id;
  logic        MemtoReg_id, ALUSrc_id;
  logic [3:0]  ALUCode_id;

  int errors = 0;
  int checks = 0;

  id_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .Instruction_if(Instruction_if), .PC_if(PC_if),
    .IF_flush(IF_flush),
    .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .Rd_ex(Rd_ex),
    .RegWrite_mem(RegWrite_mem), .MemRead_mem(MemRead_mem),
    .Rd_mem(Rd_mem), .ALUResult_mem(ALUResult_mem),
    .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .IFWrite(IFWrite), .PC_id(PC_id),
    .Rs1Data_id(Rs1Data_id), .Rs2Data_id(Rs2Data_id),
    .Imm_id(Imm_id), .Rs1_id(Rs1_id), .Rs2_id(Rs2_id),
    .Rd_id(Rd_id), .RegWrite_id(RegWrite_id),
    .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemtoReg_id(MemtoReg_id), .ALUSrc_id(ALUSrc_id),
    .ALUCode_id(ALUCode_id)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_ins, m_pc;
  bit          m_ok = 1'b0;

  alu_code_e tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                         ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite_wb && WriteReg_wb == a) return WriteData_wb;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] a);
    if (RegWrite_mem && !MemRead_mem && Rd_mem != 0 && Rd_mem == a)
      return ALUResult_mem;
    return m_read(a);
  endfunction

  function automatic bit m_uses(input logic [4:0] r);
    logic [6:0] op;
    bit u1, u2;
    op = m_ins[6:0];
    u1 = op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    u2 = op inside {7'h63, 7'h23, 7'h33};
    return r != 0 && ((u1 && m_ins[19:15] == r) ||
                      (u2 && m_ins[24:20] == r));
  endfunction

  function automatic bit m_stall();
    bit brj;
    brj = m_ins[6:0] inside {7'h63, 7'h67};
    return (MemRead_ex && m_uses(Rd_ex)) ||
           (brj && RegWrite_ex && m_uses(Rd_ex)) ||
           (brj && MemRead_mem && m_uses(Rd_mem));
  endfunction

  task automatic m_check();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, ii, is_, ib, ij, iu, e_imm, e_tgt, e_r1d;
    bit st, tk, rw, mr, mw, m2r, src;
    alu_code_e e_alu;
    op  = m_ins[6:0];
    f3  = m_ins[14:12];
    st  = m_stall();
    a   = m_opnd(m_ins[19:15]);
    b   = m_opnd(m_ins[24:20]);
    ii  = 32'($signed(m_ins) >>> 20);
    is_ = (ii & ~32'h1F) | 32'(m_ins[11:7]);
    ib  = (m_ins[31] ? 32'hFFFF_F000 : 32'h0) +
          32'(m_ins[7]) * 2048 + 32'(m_ins[30:25]) * 32 +
          32'(m_ins[11:8]) * 2;
    ij  = (m_ins[31] ? 32'hFFF0_0000 : 32'h0) +
          32'(m_ins[19:12]) * 4096 + 32'(m_ins[20]) * 2048 +
          32'(m_ins[30:21]) * 2;
    iu  = m_ins & 32'hFFFF_F000;
    case (f3)
      3'd0: tk = a == b;
      3'd1: tk = a != b;
      3'd4: tk = $signed(a) < $signed(b);
      3'd5: tk = $signed(a) >= $signed(b);
      3'd6: tk = a < b;
      3'd7: tk = a >= b;
      default: tk = 1'b0;
    endcase
    {rw, mr, mw, m2r, src} = 5'b0;
    e_alu = ALU_ADD;
    e_imm = 32'h0;
    e_tgt = m_pc + ib;
    e_r1d = m_read(m_ins[19:15]);
    case (op)
      7'h37: begin rw = 1; src = 1; e_alu = ALU_LUI; e_imm = iu; end
      7'h17: begin rw = 1; src = 1; e_imm = iu; e_r1d = m_pc; end
      7'h6F: begin
        rw = 1; src = 1; e_imm = 4; e_r1d = m_pc; e_tgt = m_pc + ij;
      end
      7'h67: begin
        rw = 1; src = 1; e_imm = 4; e_r1d = m_pc;
        e_tgt = (a + ii) & ~32'h1;
      end
      7'h63: e_imm = ib;
      7'h03: begin rw = 1; mr = 1; m2r = 1; src = 1; e_imm = ii; end
      7'h23: begin mw = 1; src = 1; e_imm = is_; end
      7'h13: begin
        rw = 1; src = 1; e_imm = ii; e_alu = tbl[f3];
        if (f3 == 5 && m_ins[30]) e_alu = ALU_SRA;
      end
      7'h33: begin
        rw = 1; e_alu = tbl[f3];
        if (f3 == 5 && m_ins[30]) e_alu = ALU_SRA;
        if (f3 == 0 && m_ins[30]) e_alu = ALU_SUB;
      end
      default: ;
    endcase
    chk("IFWrite", IFWrite, !st);
    chk("Branch", Branch, op == 7'h63 && tk && !st);
    chk("Jump", Jump, (op == 7'h6F || op == 7'h67) && !st);
    if (op inside {7'h63, 7'h6F, 7'h67}) chk("JumpAddr", JumpAddr, e_tgt);
    chk("PC_id", PC_id, m_pc);
    chk("Rs1_id", Rs1_id, m_ins[19:15]);
    chk("Rs2_id", Rs2_id, m_ins[24:20]);
    chk("Rd_id", Rd_id, m_ins[11:7]);
    chk("Rs1Data", Rs1Data_id, e_r1d);
    chk("Rs2Data", Rs2Data_id, m_read(m_ins[24:20]));
    chk("Imm", Imm_id, e_imm);
    chk("RegWrite", RegWrite_id, rw && !st);
    chk("MemRead", MemRead_id, mr && !st);
    chk("MemWrite", MemWrite_id, mw && !st);
    chk("MemtoReg", MemtoReg_id, m2r);
    chk("ALUSrc", ALUSrc_id, src);
    chk("ALUCode", ALUCode_id, e_alu);
  endtask

  task automatic m_update();
    bit st;
    st = m_stall();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_ins = 32'h13;
      m_pc  = 32'h0;
      m_ok  = 1'b1;
    end else begin
      if (RegWrite_wb && WriteReg_wb != 0) m_rf[WriteReg_wb] = WriteData_wb;
      if (!st) begin
        m_ins = IF_flush ? 32'h13 : Instruction_if;
        m_pc  = PC_if;
      end
    end
  endtask

  task automatic settle();
    #1;
    if (m_ok) m_check();
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; IF_flush = 0;
    Instruction_if = 32'h13; PC_if = 32'h0;
    RegWrite_wb = 0; WriteReg_wb = 0; WriteData_wb = 0;
    RegWrite_ex = 0; MemRead_ex = 0; Rd_ex = 0;
    RegWrite_mem = 0; MemRead_mem = 0; Rd_mem = 0;
    ALUResult_mem = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    RegWrite_wb = 1; WriteReg_wb = a; WriteData_wb = d;
    settle(); tick();
    RegWrite_wb = 0;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    Instruction_if = ins; PC_if = pc;
    settle(); tick();
    Instruction_if = 32'h13;
  endtask

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] x;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3, bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    x  = $urandom;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return {x[31:12], rd, 7'h37};
      1: return {x[31:12], rd, 7'h17};
      2: return {x[31:12], rd, 7'h6F};
      3: return {x[31:20], r1, 3'd0, rd, 7'h67};
      4: return {x[31:25], r2, r1, bf[$urandom_range(0, 5)], x[11:7], 7'h63};
      5: return {x[31:20], r1, 3'd2, rd, 7'h03};
      6: return {x[31:25], r2, r1, 3'd2, x[11:7], 7'h23};
      7: return {x[31:20], r1, f3, rd, 7'h13};
      8: return {1'b0, x[30], 5'd0, r2, r1, f3, rd, 7'h33};
      default: return {x[31:7], 7'h0B};
    endcase
  endfunction

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    settle(); tick();
    settle(); tick();
    reset = 0;
    settle();
    chk("rst_pc", PC_id, 32'h0);
    chk("rst_ifwrite", IFWrite, 1'b1);
    chk("rst_branch", Branch, 1'b0);
    chk("rst_jump", Jump, 1'b0);
    chk("rst_jaddr", JumpAddr, 32'h0);
    chk("rst_rs1d", Rs1Data_id, 32'h0);
    chk("rst_imm", Imm_id, 32'h0);
    chk("rst_nop_rw", RegWrite_id, 1'b1);
    chk("rst_nop_rd", Rd_id, 5'd0);
    tick();

    wb(5'd0, 32'hFFFF_FFFF);
    load(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd7), 32'h4);
    settle();
    chk("x0_rs1", Rs1Data_id, 32'h0);
    chk("x0_rs2", Rs2Data_id, 32'h0);
    tick();
    load(enc_i(12'd0, 5'd4, 3'd0, 5'd5, 7'h13), 32'h8);
    RegWrite_wb = 1; WriteReg_wb = 5'd4; WriteData_wb = 32'h1234;
    settle();
    chk("bypass", Rs1Data_id, 32'h1234);
    tick();
    idle();

    load(enc_i(12'd0, 5'd0, 3'd2, 5'd5, 7'h03), 32'h10);
    load(enc_r(7'd0, 5'd1, 5'd5, 3'd0, 5'd6), 32'h14);
    MemRead_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd5;
    Instruction_if = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);
    PC_if = 32'h18;
    settle();
    chk("lu_ifwrite", IFWrite, 1'b0);
    chk("lu_rw", RegWrite_id, 1'b0);
    chk("lu_mr", MemRead_id, 1'b0);
    tick();
    MemRead_ex = 0; RegWrite_ex = 0; Rd_ex = 0;
    RegWrite_mem = 1; MemRead_mem = 1; Rd_mem = 5'd5;
    settle();
    chk("lu_resume", IFWrite, 1'b1);
    chk("lu_rd", Rd_id, 5'd6);
    chk("lu_pc", PC_id, 32'h14);
    chk("lu_rw2", RegWrite_id, 1'b1);
    tick();
    idle();

    wb(5'd1, 32'h7);
    wb(5'd2, 32'h7);
    load(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h40);
    Instruction_if = enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13);
    PC_if = 32'h44; IF_flush = 1;
    settle();
    chk("beq_taken", Branch, 1'b1);
    chk("beq_addr", JumpAddr, 32'h50);
    tick();
    idle();
    settle();
    chk("flush_rd", Rd_id, 5'd0);
    chk("flush_pc", PC_id, 32'h44);
    tick();

    load(enc_i(12'd5, 5'd0, 3'd0, 5'd3, 7'h13), 32'h1C);
    load(enc_b(13'h1FF8, 5'd0, 5'd3, 3'd1), 32'h20);
    RegWrite_ex = 1; Rd_ex = 5'd3;
    settle();
    chk("fwd_stall", IFWrite, 1'b0);
    chk("fwd_nobr", Branch, 1'b0);
    tick();
    RegWrite_ex = 0; Rd_ex = 0;
    RegWrite_mem = 1; Rd_mem = 5'd3; ALUResult_mem = 32'h5;
    settle();
    chk("fwd_go", IFWrite, 1'b1);
    chk("fwd_branch", Branch, 1'b1);
    chk("fwd_addr", JumpAddr, 32'h18);
    IF_flush = 1;
    tick();
    idle();

    load(enc_i(12'd0, 5'd0, 3'd2, 5'd3, 7'h03), 32'h60);
    load(enc_b(13'h1FF8, 5'd0, 5'd3, 3'd1), 32'h64);
    MemRead_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd3;
    settle();
    chk("lwbr_stall1", IFWrite, 1'b0);
    tick();
    MemRead_ex = 0; RegWrite_ex = 0; Rd_ex = 0;
    MemRead_mem = 1; RegWrite_mem = 1; Rd_mem = 5'd3;
    settle();
    chk("lwbr_stall2", IFWrite, 1'b0);
    tick();
    MemRead_mem = 0; RegWrite_mem = 0; Rd_mem = 0;
    RegWrite_wb = 1; WriteReg_wb = 5'd3; WriteData_wb = 32'h9;
    settle();
    chk("lwbr_go", IFWrite, 1'b1);
    chk("lwbr_branch", Branch, 1'b1);
    chk("lwbr_addr", JumpAddr, 32'h5C);
    IF_flush = 1;
    tick();
    idle();

    wb(5'd1, 32'h103);
    load(enc_i(12'd4, 5'd1, 3'd0, 5'd2, 7'h67), 32'h80);
    settle();
    chk("jalr_jump", Jump, 1'b1);
    chk("jalr_addr", JumpAddr, 32'h106);
    chk("jalr_rs1d", Rs1Data_id, 32'h80);
    chk("jalr_imm", Imm_id, 32'h4);
    chk("jalr_rw", RegWrite_id, 1'b1);
    chk("jalr_rd", Rd_id, 5'd2);
    IF_flush = 1;
    tick();
    idle();

    load(enc_r(7'd0, 5'd1, 5'd5, 3'd0, 5'd6), 32'h90);
    MemRead_ex = 1; Rd_ex = 5'd5; reset = 1;
    settle();
    chk("rstall_stall", IFWrite, 1'b0);
    tick();
    idle();
    settle();
    chk("rstall_pc", PC_id, 32'h0);
    chk("rstall_clear", IFWrite, 1'b1);
    tick();

    for (int n = 0; n < 800; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      Instruction_if = rnd_instr();
      PC_if          = $urandom & ~32'h3;
      IF_flush       = ($urandom_range(0, 7) == 0);
      RegWrite_wb    = 1'($urandom_range(0, 1));
      WriteReg_wb    = 5'($urandom_range(0, 7));
      WriteData_wb   = rnd_val();
      RegWrite_ex    = 1'($urandom_range(0, 1));
      MemRead_ex     = ($urandom_range(0, 3) == 0);
      Rd_ex          = 5'($urandom_range(0, 7));
      RegWrite_mem   = 1'($urandom_range(0, 1));
      MemRead_mem    = ($urandom_range(0, 3) == 0);
      Rd_mem         = 5'($urandom_range(0, 7));
      ALUResult_mem  = rnd_val();
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
